// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default operand width for serial_adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/serial_adder_fulladder.sv
// fulladder: one-bit full adder used as the serial adder's datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, WIDTH cycles per operation.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_sum;
  logic             r_carry, r_cout;
  logic             w_s, w_co;
  logic             w_last;
  fulladder u_fa (.a(r_a[0]), .b(r_b[0]), .c(r_carry), .s(w_s), .cout(w_co));
  assign w_last = r_cnt == LAST;
  // Results are published only on the final shift edge so sum never shows partial bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sh    <= {w_s, r_sh[WIDTH-1:1]};
      r_carry <= w_co;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_state <= DONE;
        r_sum   <= {w_s, r_sh[WIDTH-1:1]};
        r_cout  <= w_co;
      end
    end else if (start) begin
      r_state <= SHIFT;
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else begin
      r_state <= IDLE;
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  // On the last shift the registered carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (reset) r_ovf <= 1'b0;
    else if (r_state == SHIFT && w_last) r_ovf <= r_carry ^ w_co;
  end
  assign ovf = r_ovf;
`endif
  assign busy = r_state == SHIFT;
  assign done = r_state == DONE;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven check of serial_adder (WIDTH=8) plus corner sequences.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       reset, start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
  int total = 0;
  int bad = 0;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(output int n, output int bc, output int chg);
    logic [7:0] held;
    held = sum;
    n = 0; bc = 0; chg = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      if (sum !== held) chg++;
      tick();
      n++;
    end
  endtask
  initial begin
    int n, bc, chg, dcnt;
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
    reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);
    foreach (vecs[i]) begin
      do_start(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(n, bc, chg);
      chk($sformatf("v%0d_latency", i), 32'(n), 8);
      chk($sformatf("v%0d_busycyc", i), 32'(bc), 8);
      chk($sformatf("v%0d_sumhold", i), 32'(chg), 0);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].co));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
`endif
      tick();
      chk($sformatf("v%0d_donepulse", i), 32'(done), 0);
      chk($sformatf("v%0d_sumheld", i), 32'(sum), 32'(vecs[i].s));
    end
    // start during SHIFT must be ignored
    do_start(8'h03, 8'h04, 1'b0);
    tick();
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bc, chg);
    chk("ign_latency", 32'(n), 6);
    chk("ign_sum", 32'(sum), 8'h07);
    chk("ign_cout", 32'(cout), 0);
    tick();
    chk("ign_idle", 32'(busy), 0);
    // reset mid-operation aborts without a done pulse
    do_start(8'h10, 8'h20, 1'b0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) dcnt++;
      tick();
    end
    chk("abort_nodone", 32'(dcnt), 0);
    chk("abort_idle", 32'(busy), 0);
    // back-to-back: start accepted while done is high
    do_start(8'h12, 8'h34, 1'b1);
    wait_done(n, bc, chg);
    chk("b2b_first", 32'(sum), 8'h47);
    do_start(8'h7F, 8'h01, 1'b0);
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_hold", 32'(sum), 8'h47);
    wait_done(n, bc, chg);
    chk("b2b_latency", 32'(n + 1), 9);
    chk("b2b_sumhold", 32'(chg), 0);
    chk("b2b_sum", 32'(sum), 8'h80);
    chk("b2b_cout", 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("b2b_ovf", 32'(ovf), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
